// File: rtl/gemm_tile_sequencer_pkg.sv
// Shared configuration for the gemm tile sequencer: array geometry, gemm
// register map, DIM register layout, FSM state encoding and a small
// shift-add scaling helper used once per job to form accumulator steps.
package gemm_tile_sequencer_pkg;

  localparam int SUPER_SYS_ROWS = 16;
  localparam int SUPER_SYS_COLS = 16;

  localparam logic [31:0] GEMM_BASE_ADDR = 32'h9000_0000;

  // gemm MMIO register offsets
  localparam logic [31:0] OFF_A_ADDR   = 32'd0;
  localparam logic [31:0] OFF_B_ADDR   = 32'd4;
  localparam logic [31:0] OFF_C_ADDR   = 32'd8;
  localparam logic [31:0] OFF_A_STRIDE = 32'd12;
  localparam logic [31:0] OFF_B_STRIDE = 32'd16;
  localparam logic [31:0] OFF_CTRL     = 32'd20;
  localparam logic [31:0] OFF_DIM      = 32'd24;

  // DIM register: msize in [4:0], ksize in [9:5], nsize in [14:10]
  typedef struct packed {
    logic [4:0] nsize;
    logic [4:0] ksize;
    logic [4:0] msize;
  } gemm_dim_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_ASTR,
    S_W_BSTR,
    S_W_AADR,
    S_W_BADR,
    S_W_CADR,
    S_W_CTRL,
    S_W_DIM,
    S_P_FULL,
    S_ADV,
    S_P_DONE,
    S_FIN
  } seq_state_t;

  // v * f for a small factor f, built from shifted copies of v. Only used
  // when a job is captured, so the per-tile datapath stays adders only.
  function automatic logic [31:0] scale_small(input logic [31:0] v,
                                              input logic [7:0]  f);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      if (f[i]) acc = acc + (v << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gemm_tile_sequencer_if.sv
// System bus seen from the sequencer (master) and from gemm / the bus fabric
// (slave). Read data returns one cycle after the read request.
interface gemm_tile_sequencer_if;
  logic        bus_en;
  logic        bus_rdwr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;

  modport master (output bus_en, output bus_rdwr, output bus_addr,
                  output bus_wr_data, input bus_rd_data);
  modport slave  (input bus_en, input bus_rdwr, input bus_addr,
                  input bus_wr_data, output bus_rd_data);
endinterface

// File: rtl/gemm_tile_sequencer_iter.sv
// Tile walker: n-outer / m-middle / k-inner counters with running address
// accumulators. Every per-tile address is a register or one adder away; the
// only scaled values (step sizes, B row offsets) are formed once on init.
// BLK_K must be a power of two so the last-k remainder is a bit mask.
module gemm_tile_iter
  import gemm_tile_sequencer_pkg::*;
#(
  parameter int BLK_N = SUPER_SYS_ROWS,
  parameter int BLK_K = SUPER_SYS_COLS,
  parameter int BLK_M = 16,
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_i,
  input  logic             step_i,
  input  logic [DIM_W-1:0] dim_m_i,
  input  logic [DIM_W-1:0] dim_k_i,
  input  logic [DIM_W-1:0] dim_n_i,
  input  logic [31:0]      a_addr_i,
  input  logic [31:0]      b_addr_i,
  input  logic [31:0]      c_addr_i,
  output logic [4:0]       msize_o,
  output logic [4:0]       ksize_o,
  output logic [4:0]       nsize_o,
  output logic             first_o,
  output logic             last_o,
  output logic [31:0]      a_tile_o,
  output logic [31:0]      b_tile_o,
  output logic [31:0]      c_tile_o,
  output logic [31:0]      k_stride_o,
  output logic [31:0]      n_stride_o,
  output logic             last_tile_o
);

  localparam logic [DIM_W:0] BK = (DIM_W+1)'(BLK_K);
  localparam logic [DIM_W:0] BM = (DIM_W+1)'(BLK_M);
  localparam logic [DIM_W:0] BN = (DIM_W+1)'(BLK_N);

  logic [DIM_W-1:0] dim_m_q, dim_k_q, dim_n_q;
  logic [DIM_W-1:0] k_q, m_q, n_q;
  logic [31:0]      a_base_q, a_m_q, a_k_q;   // a, a+m*K, a+m*K+k
  logic [31:0]      b_n_q, b_k_q;             // b+n, b+k*N+n
  logic [31:0]      c_n_q, c_m_q;             // c+n, c+m*N+n
  logic [31:0]      step_am_q, step_cm_q, step_bk_q;
  logic [31:0]      b_full_q, b_tail_q;       // (ksize-1)*N for full / last k tile

  logic             last_k, last_m, last_n;
  logic [DIM_W-1:0] k_rem;

  assign last_k = ({1'b0, k_q} + BK) >= {1'b0, dim_k_q};
  assign last_m = ({1'b0, m_q} + BM) >= {1'b0, dim_m_q};
  assign last_n = ({1'b0, n_q} + BN) >= {1'b0, dim_n_q};
  assign k_rem  = (dim_k_i - DIM_W'(1)) & DIM_W'(BLK_K - 1);

  assign ksize_o     = last_k ? 5'(dim_k_q - k_q) : 5'(BLK_K);
  assign msize_o     = last_m ? 5'(dim_m_q - m_q) : 5'(BLK_M);
  assign nsize_o     = last_n ? 5'(dim_n_q - n_q) : 5'(BLK_N);
  assign first_o     = (k_q == '0);
  assign last_o      = last_k;
  assign a_tile_o    = a_k_q;
  assign b_tile_o    = b_k_q + (last_k ? b_tail_q : b_full_q);
  assign c_tile_o    = c_m_q;
  assign k_stride_o  = 32'(dim_k_q);
  assign n_stride_o  = 32'(dim_n_q);
  assign last_tile_o = last_k & last_m & last_n;

  // Capture the job on init, then advance k, m, n and their accumulators per step.
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dim_m_q   <= '0;
      dim_k_q   <= '0;
      dim_n_q   <= '0;
      k_q       <= '0;
      m_q       <= '0;
      n_q       <= '0;
      a_base_q  <= '0;
      a_m_q     <= '0;
      a_k_q     <= '0;
      b_n_q     <= '0;
      b_k_q     <= '0;
      c_n_q     <= '0;
      c_m_q     <= '0;
      step_am_q <= '0;
      step_cm_q <= '0;
      step_bk_q <= '0;
      b_full_q  <= '0;
      b_tail_q  <= '0;
    end else if (init_i) begin
      dim_m_q   <= dim_m_i;
      dim_k_q   <= dim_k_i;
      dim_n_q   <= dim_n_i;
      k_q       <= '0;
      m_q       <= '0;
      n_q       <= '0;
      a_base_q  <= a_addr_i;
      a_m_q     <= a_addr_i;
      a_k_q     <= a_addr_i;
      b_n_q     <= b_addr_i;
      b_k_q     <= b_addr_i;
      c_n_q     <= c_addr_i;
      c_m_q     <= c_addr_i;
      step_am_q <= scale_small(32'(dim_k_i), 8'(BLK_M));
      step_cm_q <= scale_small(32'(dim_n_i), 8'(BLK_M));
      step_bk_q <= scale_small(32'(dim_n_i), 8'(BLK_K));
      b_full_q  <= scale_small(32'(dim_n_i), 8'(BLK_K - 1));
      b_tail_q  <= scale_small(32'(dim_n_i), 8'(k_rem));
    end else if (step_i) begin
      if (!last_k) begin
        k_q   <= k_q + DIM_W'(BLK_K);
        a_k_q <= a_k_q + 32'(BLK_K);
        b_k_q <= b_k_q + step_bk_q;
      end else begin
        k_q <= '0;
        if (!last_m) begin
          m_q   <= m_q + DIM_W'(BLK_M);
          a_m_q <= a_m_q + step_am_q;
          a_k_q <= a_m_q + step_am_q;
          b_k_q <= b_n_q;
          c_m_q <= c_m_q + step_cm_q;
        end else begin
          m_q   <= '0;
          n_q   <= n_q + DIM_W'(BLK_N);
          a_m_q <= a_base_q;
          a_k_q <= a_base_q;
          b_n_q <= b_n_q + 32'(BLK_N);
          b_k_q <= b_n_q + 32'(BLK_N);
          c_n_q <= c_n_q + 32'(BLK_N);
          c_m_q <= c_n_q + 32'(BLK_N);
        end
      end
    end
  end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Hardware tile scheduler in front of gemm: for each tile it writes the seven
// gemm registers, polls until gemm's queue has room, and after the last tile
// polls DIM until gemm reports the job complete.
module gemm_tile_sequencer
  import gemm_tile_sequencer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = GEMM_BASE_ADDR,
  parameter int          BLK_N     = SUPER_SYS_ROWS,
  parameter int          BLK_K     = SUPER_SYS_COLS,
  parameter int          BLK_M     = 16,
  parameter int          DIM_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DIM_W-1:0] dim_m_i,
  input  logic [DIM_W-1:0] dim_k_i,
  input  logic [DIM_W-1:0] dim_n_i,
  input  logic [31:0]      a_addr_i,
  input  logic [31:0]      b_addr_i,
  input  logic [31:0]      c_addr_i,
  output logic             busy_o,
  output logic             done_o,
  gemm_tile_sequencer_if.master bus
);

  seq_state_t  state_q, state_d;
  logic        rd_pend_q;     // a read has been outstanding for at least one cycle
  logic        iter_init, iter_step;
  logic        rd_bit, unused_rd;
  logic        any_zero;

  logic [4:0]  msize, ksize, nsize;
  logic        first, last, last_tile;
  logic [31:0] a_tile, b_tile, c_tile, k_stride, n_stride;
  gemm_dim_t   dim_word;

  logic        bus_en_c, bus_rdwr_c;
  logic [31:0] bus_addr_c, bus_wr_data_c;

  assign rd_bit    = bus.bus_rd_data[0];
  assign unused_rd = ^bus.bus_rd_data[31:1];
  assign any_zero  = (dim_m_i == '0) || (dim_k_i == '0) || (dim_n_i == '0);
  assign iter_init = (state_q == S_IDLE) && start_i;
  assign iter_step = (state_q == S_ADV) && !last_tile;

  assign dim_word.msize = msize;
  assign dim_word.ksize = ksize;
  assign dim_word.nsize = nsize;

  gemm_tile_iter #(
    .BLK_N (BLK_N),
    .BLK_K (BLK_K),
    .BLK_M (BLK_M),
    .DIM_W (DIM_W)
  ) u_iter (
    .clk         (clk),
    .rst         (rst),
    .init_i      (iter_init),
    .step_i      (iter_step),
    .dim_m_i     (dim_m_i),
    .dim_k_i     (dim_k_i),
    .dim_n_i     (dim_n_i),
    .a_addr_i    (a_addr_i),
    .b_addr_i    (b_addr_i),
    .c_addr_i    (c_addr_i),
    .msize_o     (msize),
    .ksize_o     (ksize),
    .nsize_o     (nsize),
    .first_o     (first),
    .last_o      (last),
    .a_tile_o    (a_tile),
    .b_tile_o    (b_tile),
    .c_tile_o    (c_tile),
    .k_stride_o  (k_stride),
    .n_stride_o  (n_stride),
    .last_tile_o (last_tile)
  );

  // State register and read-pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= ((state_q == S_P_FULL) || (state_q == S_P_DONE)) && (state_d == state_q);
    end
  end

  // Next state and bus/status outputs decoded from the current state.
  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    bus_en_c      = 1'b0;
    bus_rdwr_c    = 1'b0;
    bus_addr_c    = '0;
    bus_wr_data_c = '0;
    busy_o        = (state_q != S_IDLE) && (state_q != S_FIN);
    done_o        = (state_q == S_FIN);
    case (state_q)
      S_IDLE: if (start_i) state_d = any_zero ? S_FIN : S_W_ASTR;
      S_W_ASTR: begin
        bus_en_c = 1'b1; bus_rdwr_c = 1'b1;
        bus_addr_c = BASE_ADDR + OFF_A_STRIDE; bus_wr_data_c = k_stride;
        state_d = S_W_BSTR;
      end
      S_W_BSTR: begin
        bus_en_c = 1'b1; bus_rdwr_c = 1'b1;
        bus_addr_c = BASE_ADDR + OFF_B_STRIDE; bus_wr_data_c = n_stride;
        state_d = S_W_AADR;
      end
      S_W_AADR: begin
        bus_en_c = 1'b1; bus_rdwr_c = 1'b1;
        bus_addr_c = BASE_ADDR + OFF_A_ADDR; bus_wr_data_c = a_tile;
        state_d = S_W_BADR;
      end
      S_W_BADR: begin
        bus_en_c = 1'b1; bus_rdwr_c = 1'b1;
        bus_addr_c = BASE_ADDR + OFF_B_ADDR; bus_wr_data_c = b_tile;
        state_d = S_W_CADR;
      end
      S_W_CADR: begin
        bus_en_c = 1'b1; bus_rdwr_c = 1'b1;
        bus_addr_c = BASE_ADDR + OFF_C_ADDR; bus_wr_data_c = c_tile;
        state_d = S_W_CTRL;
      end
      S_W_CTRL: begin
        bus_en_c = 1'b1; bus_rdwr_c = 1'b1;
        bus_addr_c = BASE_ADDR + OFF_CTRL; bus_wr_data_c = {30'b0, first, last};
        state_d = S_W_DIM;
      end
      S_W_DIM: begin
        bus_en_c = 1'b1; bus_rdwr_c = 1'b1;
        bus_addr_c = BASE_ADDR + OFF_DIM; bus_wr_data_c = 32'(dim_word);
        state_d = S_P_FULL;
      end
      S_P_FULL: begin
        bus_en_c = 1'b1;
        bus_addr_c = BASE_ADDR + OFF_A_ADDR;
        if (rd_pend_q && !rd_bit) state_d = S_ADV;
      end
      S_ADV: state_d = last_tile ? S_P_DONE : S_W_ASTR;
      S_P_DONE: begin
        bus_en_c = 1'b1;
        bus_addr_c = BASE_ADDR + OFF_DIM;
        if (rd_pend_q && rd_bit) state_d = S_FIN;
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.bus_en      = bus_en_c;
  assign bus.bus_rdwr    = bus_rdwr_c;
  assign bus.bus_addr    = bus_addr_c;
  assign bus.bus_wr_data = bus_wr_data_c;

endmodule
